// File: rtl/i2s_pkg.sv
// Shared I2S definitions: default word sizing, receiver state encoding and
// ws channel codes common to the transmit and receive paths.
package i2s_pkg;

  localparam int WORD_W_DEF = 32;
  localparam int CNT_W_DEF  = 6;

  localparam logic WS_LEFT  = 1'b0;
  localparam logic WS_RIGHT = 1'b1;

  typedef enum logic [1:0] {
    SYNC,
    LEFT,
    RIGHT
  } state_t;

endpackage

// File: rtl/i2s_pin_sync.sv
// Two-flop pin synchroniser. With EDGE=1 the output is instead a one-clk
// registered pulse on each rising edge of the synchronised level.
module i2s_pin_sync #(
  parameter bit EDGE = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic s1;
  logic s2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= d;
      s2 <= s1;
    end
  end

  generate
    if (EDGE) begin : g_edge
      logic s2_d;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          s2_d <= 1'b0;
          q    <= 1'b0;
        end else begin
          s2_d <= s2;
          q    <= s2 & ~s2_d;
        end
      end
    end else begin : g_level
      assign q = s2;
    end
  endgenerate

endmodule

// File: rtl/i2s_rx.sv
// I2S receiver: deserialises standard-framed left/right words into stereo
// pairs on a valid/ready output. Define I2S_RX_OVERRUN_CNT_EN for overrun_cnt/cnt_clr.
module i2s_rx
  import i2s_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sck,
  input  logic              ws,
  input  logic              sd,
  output logic [WORD_W-1:0] out_left,
  output logic [WORD_W-1:0] out_right,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              overrun
`ifdef I2S_RX_OVERRUN_CNT_EN
  ,
  input  logic              cnt_clr,
  output logic [7:0]        overrun_cnt
`endif
);

  logic sck_rise;
  logic ws_s;
  logic sd_s;

  i2s_pin_sync #(.EDGE(1'b1)) u_sck (.clk(clk), .rst(rst), .d(sck), .q(sck_rise));
  i2s_pin_sync #(.EDGE(1'b0)) u_ws  (.clk(clk), .rst(rst), .d(ws),  .q(ws_s));
  i2s_pin_sync #(.EDGE(1'b0)) u_sd  (.clk(clk), .rst(rst), .d(sd),  .q(sd_s));

  state_t            state;
  logic              ws_last;
  logic [CNT_W-1:0]  bit_cnt;
  logic [WORD_W-1:0] shreg;
  logic [WORD_W-1:0] left_hold;

  logic [WORD_W-1:0] sh_next;
  logic [WORD_W-1:0] commit;
  logic [31:0]       cnt_ext;
  logic [31:0]       captured;
  logic              shift_in;
  logic              pair_commit;
  logic              drop;

  // The boundary bit is the closing word's LSB, so commit sees the shift
  // including this edge's bit; the result is left-aligned to WORD_W.
  always_comb begin
    cnt_ext     = 32'(bit_cnt);
    shift_in    = cnt_ext < 32'(WORD_W);
    sh_next     = shift_in ? {shreg[WORD_W-2:0], sd_s} : shreg;
    captured    = shift_in ? cnt_ext + 32'd1 : 32'(WORD_W);
    commit      = (bit_cnt == '0) ? '0 : sh_next << (32'(WORD_W) - captured);
    pair_commit = sck_rise && (ws_s != ws_last) && (state == RIGHT);
    drop        = pair_commit && out_valid && !out_ready;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= SYNC;
      ws_last   <= 1'b0;
      bit_cnt   <= '0;
      shreg     <= '0;
      left_hold <= '0;
      out_left  <= '0;
      out_right <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (out_valid && out_ready)
        out_valid <= 1'b0;
      if (pair_commit) begin
        if (drop) begin
          overrun <= 1'b1;
        end else begin
          out_left  <= left_hold;
          out_right <= commit;
          out_valid <= 1'b1;
        end
      end

      if (sck_rise) begin
        ws_last <= ws_s;
        unique case (state)
          SYNC: begin
            if (ws_s == WS_LEFT && ws_last == WS_RIGHT) begin
              state   <= LEFT;
              bit_cnt <= '0;
              shreg   <= '0;
            end
          end
          LEFT, RIGHT: begin
            if (ws_s != ws_last) begin
              if (state == LEFT)
                left_hold <= commit;
              shreg   <= '0;
              bit_cnt <= '0;
              state   <= (state == LEFT) ? RIGHT : LEFT;
            end else begin
              shreg <= sh_next;
              if (!(&bit_cnt))
                bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end
          default: state <= SYNC;
        endcase
      end
    end
  end

`ifdef I2S_RX_OVERRUN_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      overrun_cnt <= '0;
    else if (cnt_clr)
      overrun_cnt <= '0;
    else if (drop && overrun_cnt != 8'hFF)
      overrun_cnt <= overrun_cnt + 8'd1;
  end
`endif

endmodule

// File: tb/tb_i2s_rx.sv
// Scoreboard bench for i2s_rx: directed I2S frames, expected pairs queued at
// stimulus time and popped by a monitor on each out_valid && out_ready.
module tb_i2s_rx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sck = 1'b0;
  logic        ws  = 1'b0;
  logic        sd  = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] out_left;
  logic [31:0] out_right;
  logic        out_valid;
  logic        overrun;
`ifdef I2S_RX_OVERRUN_CNT_EN
  logic        cnt_clr = 1'b0;
  logic [7:0]  overrun_cnt;
`endif

  int          checks   = 0;
  int          failures = 0;
  int          ovr_seen = 0;
  logic        carry    = 1'b0;
  logic [63:0] sb[$];

  i2s_rx #(.WORD_W(32), .CNT_W(6)) dut (
    .clk(clk),
    .rst(rst),
    .sck(sck),
    .ws(ws),
    .sd(sd),
    .out_left(out_left),
    .out_right(out_right),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .overrun(overrun)
`ifdef I2S_RX_OVERRUN_CNT_EN
    ,
    .cnt_clr(cnt_clr),
    .overrun_cnt(overrun_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [71:0] got, input logic [71:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h required=%h", name, got, exp);
    end
  endtask

  // Monitor: one pair per accepted handshake, compared against the queue head.
  always @(negedge clk) begin
    if (overrun)
      ovr_seen++;
    if (!rst && out_valid && out_ready) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_pair got=%h_%h required=none", out_left, out_right);
      end else begin
        logic [63:0] exp;
        exp = sb.pop_front();
        if ({out_left, out_right} !== exp) begin
          failures++;
          $display("FAIL pair got=%h_%h required=%h_%h", out_left, out_right,
                   exp[63:32], exp[31:0]);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // One sck period: ws/sd change with sck falling, 4 clk low then 4 clk high.
  task automatic slot(input logic w, input logic d);
    sck = 1'b0;
    ws  = w;
    sd  = d;
    repeat (4) @(negedge clk);
    sck = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  // Standard framing: sd lags ws by one slot; slot 0 carries the previous right LSB.
  task automatic send_frame(input logic [63:0] l, input logic [63:0] r, input int n);
    for (int j = 0; j < 2 * n; j++) begin
      if (j == 0)
        slot(1'b0, carry);
      else if (j <= n)
        slot(j >= n, l[n - j]);
      else
        slot(1'b1, r[2 * n - j]);
    end
    carry = r[0];
  endtask

  task automatic preamble;
    slot(1'b1, 1'b0);
    slot(1'b1, 1'b0);
    carry = 1'b0;
  endtask

  task automatic do_reset(input string name);
    rst = 1'b1;
    sck = 1'b0;
    ws  = 1'b0;
    sd  = 1'b0;
    repeat (3) @(posedge clk);
    #1 check(name, 72'({out_valid, overrun, out_left, out_right}), 72'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 200 && sb.size() != 0; i++)
      @(negedge clk);
    repeat (20) @(negedge clk);
    check(name, 72'(sb.size()), 72'd0);
  endtask

  initial begin
    int ovr_base;

    // 1: single frame, latency from the closing sck edge
    do_reset("t1_reset");
    preamble();
    sb.push_back({32'hA5A5_0001, 32'h1234_5678});
    send_frame(64'hA5A5_0001, 64'h1234_5678, 32);
    check("t1_no_pair_before_close", 72'(out_valid), 72'd0);
    sck = 1'b0;
    ws  = 1'b0;
    sd  = carry;
    repeat (4) @(negedge clk);
    sck = 1'b1;
    repeat (3) @(posedge clk);
    #1 check("t1_latency_3clk", 72'(out_valid), 72'd0);
    @(posedge clk);
    #1 check("t1_latency_4clk", 72'(out_valid), 72'd1);
    check("t1_pair", 72'({out_left, out_right}), 72'({32'hA5A5_0001, 32'h1234_5678}));
    @(negedge clk);
    drain("t1_drain");

    // 2: eight back-to-back frames with ready held high
    do_reset("t2_reset");
    ovr_base = ovr_seen;
    preamble();
    for (int i = 0; i < 8; i++) begin
      logic [31:0] l;
      logic [31:0] r;
      l = 32'h8000_0001 + 32'(i) * 32'h0001_0010;
      r = 32'h0F0F_0000 + 32'(i);
      sb.push_back({l, r});
      send_frame(64'(l), 64'(r), 32);
    end
    slot(1'b0, carry);
    drain("t2_drain");
    check("t2_no_overrun", 72'(ovr_seen - ovr_base), 72'd0);

    // 3: consumer stalled across two pairs
    do_reset("t3_reset");
    out_ready = 1'b0;
    ovr_base  = ovr_seen;
    preamble();
    sb.push_back({32'hCAFE_F00D, 32'h0BAD_BEEF});
    send_frame(64'hCAFE_F00D, 64'h0BAD_BEEF, 32);
    send_frame(64'h1111_2222, 64'h3333_4444, 32);
    check("t3_first_held", 72'({out_valid, out_left, out_right}),
          72'({1'b1, 32'hCAFE_F00D, 32'h0BAD_BEEF}));
    slot(1'b0, carry);
    repeat (10) @(negedge clk);
    check("t3_overrun_once", 72'(ovr_seen - ovr_base), 72'd1);
    check("t3_still_first", 72'({out_valid, out_left, out_right}),
          72'({1'b1, 32'hCAFE_F00D, 32'h0BAD_BEEF}));
`ifdef I2S_RX_OVERRUN_CNT_EN
    check("t3_overrun_cnt", 72'(overrun_cnt), 72'd1);
    @(posedge clk);
    #1 cnt_clr = 1'b1;
    @(posedge clk);
    #1 cnt_clr = 1'b0;
    check("t3_overrun_cnt_clr", 72'(overrun_cnt), 72'd0);
`endif
    @(posedge clk);
    #1 out_ready = 1'b1;
    drain("t3_drain");
    check("t3_second_not_visible", 72'(out_valid), 72'd0);

    // 4: 24-bit channels zero-padded at the LSB end
    do_reset("t4_reset");
    preamble();
    sb.push_back({32'hABCD_EF00, 32'h1234_5600});
    send_frame(64'hAB_CDEF, 64'h12_3456, 24);
    slot(1'b0, carry);
    drain("t4_drain");

    // 5: 40-bit channels truncated to the top 32 bits
    do_reset("t5_reset");
    preamble();
    sb.push_back({32'hDEAD_BEEF, 32'h0102_0304});
    send_frame(64'hDE_ADBE_EF5A, 64'h01_0203_0405, 40);
    slot(1'b0, carry);
    drain("t5_drain");

    // 6: reset mid-left-word, then resynchronise
    do_reset("t6_reset");
    preamble();
    slot(1'b0, carry);
    for (int i = 0; i < 10; i++)
      slot(1'b0, 1'b1);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 check("t6_in_reset", 72'({out_valid, overrun, out_left, out_right}), 72'd0);
    @(negedge clk);
    rst = 1'b0;
    send_frame(64'h5555_AAAA, 64'hAAAA_5555, 32);
    check("t6_no_pair_before_sync", 72'({out_valid, out_left, out_right}), 72'd0);
    sb.push_back({32'h0F1E_2D3C, 32'h4B5A_6978});
    send_frame(64'h0F1E_2D3C, 64'h4B5A_6978, 32);
    slot(1'b0, carry);
    drain("t6_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/i2s_rx.md
Name: i2s_rx

Overview:
I2S receiver and deserializer: the inverse of the existing I2S transmit path that shifts 32-bit words out serially under an LR clock.
- Samples external sck/ws/sd pins in the clk domain.
- Reassembles MSB-first left/right words using standard I2S framing (data delayed one sck after each ws edge).
- Presents each completed stereo pair on a valid/ready interface to downstream filter/pitch logic.

Parameters:
WORD_W, 32, bits kept per channel; received bits beyond WORD_W are discarded, short words are zero-padded at the LSB end.
CNT_W, 6, width of per-channel bit counter; must satisfy 2^CNT_W > max bits per ws half-period.

Ports:
clk  input  1  system clock; must be at least 4x sck frequency.
rst  input  1  asynchronous, active-high reset.
sck  input  1  I2S bit clock from pin, asynchronous to clk.
ws  input  1  I2S word select from pin (0 = left, 1 = right), asynchronous.
sd  input  1  I2S serial data from pin, asynchronous.
out_left  output  WORD_W  left sample of the held pair.
out_right  output  WORD_W  right sample of the held pair.
out_valid  output  1  pair held and available.
out_ready  input  1  consumer accepts the pair when out_valid && out_ready.
overrun  output  1  one-clk pulse when a completed pair is dropped.

Behaviour:
- Pin synchronisation:
  - sck, ws and sd each pass through 2-flop synchronisers.
  - sck_rise is a registered-edge detect on synchronised sck; ws and sd are used at the sck_rise cycle.
- State machine:
  - SYNC (reset state): ignore data until sck_rise with ws_s=1 followed by a sck_rise with ws_s=0, i.e. the first left-channel start. Then go to LEFT with bit_cnt=0.
  - LEFT / RIGHT: on each sck_rise, if ws_s equals ws_last:
    - when bit_cnt < WORD_W, shift sd into shreg at the LSB;
    - increment bit_cnt, saturating at all-ones.
  - LEFT / RIGHT: on sck_rise where ws_s != ws_last (channel boundary), the bit sampled at this edge is the LSB of the closing word:
    - shift it in if bit_cnt < WORD_W;
    - commit shreg left-aligned (shift left by WORD_W - bits captured, zero fill) to left_hold (closing LEFT) or right_hold (closing RIGHT);
    - clear shreg and bit_cnt; switch state.
  - ws_last updates on every sck_rise.
- Pair output:
  - On commit of RIGHT, load out_left <= left_hold and out_right <= committed right in the next clk.
  - out_valid asserts in that same clk.
  - Latency: out_valid rises 4 clk after the sck rising edge at the pin (2 sync, 1 edge, 1 commit/present).
- Handshake:
  - out_left, out_right and out_valid hold stable while out_valid && !out_ready.
  - Transfer occurs when out_valid && out_ready; out_valid drops next clk unless a new pair commits in the same cycle, in which case the new pair loads and out_valid stays 1.
  - If a new pair commits while out_valid && !out_ready: keep the old pair, drop the new one, pulse overrun for one clk.
- Zero-length channel: a boundary with bit_cnt=0 (glitch) commits zero.
- Reset: all outputs 0, state SYNC, shreg/holds/counters 0. Reset mid-word discards partial data; the block resynchronises via SYNC.

Optional Feature:
I2S_RX_OVERRUN_CNT_EN:
- When defined: adds output overrun_cnt [7:0]. It is a saturating count of dropped pairs (stays at 255), reset to 0, cleared by a one-clk pulse on added input cnt_clr. Clear wins over a simultaneous increment.
- When undefined: neither port exists; only the overrun pulse is provided.

Decomposition:
- Package i2s_pkg:
  - WORD_W default constant;
  - state enum (SYNC, LEFT, RIGHT);
  - channel encoding constants (WS_LEFT=0, WS_RIGHT=1), shared with the transmit path.
- Sub-module i2s_pin_sync: 2-flop synchroniser plus rising-edge detect, instantiated for sck; ws and sd use its plain synchroniser mode.

Test Plan:
1. Reset then one full frame (32 sck per channel), left=0xA5A5_0001, right=0x1234_5678 -> after SYNC frame, out_valid=1, out_left=0xA5A5_0001, out_right=0x1234_5678, 4 clk after final edge.
2. out_ready held 1, 8 consecutive frames of incrementing values -> 8 pairs delivered in order, overrun never pulses.
3. out_ready held 0 across two completed frames -> first pair held stable, overrun pulses once, the second pair is not visible; overrun_cnt=1 when the optional feature is enabled.
4. 24-bit channels (24 sck per half), left=0xABCDEF -> out_left=0xABCDEF00.
5. 40-bit channels with left MSBs 0xDEADBEEF followed by 8 extra bits -> out_left=0xDEADBEEF, extra bits discarded.
6. Assert rst mid-left-word, release -> outputs 0, no pair emitted until a complete frame following a ws 1->0 edge.
